mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port between the instruction-fetch path (IF) and the load/store path (LS).
//  Round-robin arbitration with grant lock while the memory stalls.
//  Tracks up to OUTSTANDING in-order transactions and routes each response to its owner.
//  Sits between the control/fetch sequencer and the memory model.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width; strobe width is DATA_W/8
//  OUTSTANDING  2   max accepted-but-unanswered requests; power of 2, >=1
// PORTS
//  clk            in   1         single clock, all state on posedge
//  rst            in   1         synchronous, active-high reset
//  if_req_valid   in   1         fetch request
//  if_req_ready   out  1         fetch request accepted this cycle
//  if_req_addr    in   ADDR_W    fetch address
//  if_resp_valid  out  1         fetch data valid
//  if_resp_data   out  DATA_W    fetch data
//  ls_req_valid   in   1         load/store request
//  ls_req_ready   out  1         load/store request accepted this cycle
//  ls_req_addr    in   ADDR_W    load/store address
//  ls_req_we      in   1         1 = store
//  ls_req_wdata   in   DATA_W    store data
//  ls_req_wstrb   in   DATA_W/8  store byte enables
//  ls_resp_valid  out  1         load data / store ack
//  ls_resp_data   out  DATA_W    load data; don't-care for stores
//  mem_req_valid  out  1         request to memory
//  mem_req_ready  in   1         memory accepts
//  mem_req_addr   out  ADDR_W    forwarded address
//  mem_req_we     out  1         0 when IF granted
//  mem_req_wdata  out  DATA_W    0 when IF granted
//  mem_req_wstrb  out  DATA_W/8  0 when IF granted
//  mem_resp_valid in   1         in-order response, one per accepted request (stores too)
//  mem_resp_data  in   DATA_W    response data
//  err_orphan     out  1         sticky: response arrived with nothing outstanding
// BEHAVIOUR
//  - Reset:
//    - owner FIFO empty; count = 0; rr pointer = favour IF; lock clear; err_orphan = 0.
//    - All *_valid and *_ready outputs are 0 while rst = 1.
//  - Handshake: a transfer occurs when valid && ready in the same cycle.
//    - Requesters hold valid and payload stable until ready.
//    - Memory likewise sees stable mem_req_* until mem_req_ready.
//  - Arbiter FSM, states ARB_IDLE and ARB_HOLD:
//    - ARB_IDLE:
//      - If count == OUTSTANDING, grant nobody; mem_req_valid = 0.
//      - Otherwise grant the sole requester. If both request, grant the one favoured by the rr pointer.
//      - If granted and !mem_req_ready, go to ARB_HOLD with the grant latched.
//      - On a transfer, flip the rr pointer to favour the other requester.
//    - ARB_HOLD:
//      - Keep the latched grant; the other requester is ignored.
//      - Return to ARB_IDLE on mem_req_ready.
//  - Request path is combinational, 0 cycles:
//    - mem_req_* = granted requester payload.
//    - x_req_ready = granted && mem_req_ready.
//  - Owner FIFO holds 1 bit per transaction (0 = IF, 1 = LS):
//    - Push on every mem_req transfer.
//    - Pop on every mem_resp_valid when count > 0.
//  - Response routing is combinational, 0 cycles:
//    - If head == IF: if_resp_valid = mem_resp_valid; otherwise ls_resp_valid = mem_resp_valid.
//    - Both resp_data outputs = mem_resp_data.
//  - Full uses the registered count: a pop in the same cycle does not allow a grant while full.
//    - Push+pop when not full leaves count unchanged.
//  - mem_resp_valid with count == 0:
//    - Both resp_valid stay 0 and nothing is popped.
//    - err_orphan is set and held until rst.
//  - Pointers wrap modulo OUTSTANDING; count ranges 0..OUTSTANDING.
//  - Reset mid-operation drops all outstanding ownership; later memory responses count as orphans.
// TESTING
//  - Reset:
//    - Stimulus: rst high 2 cycles, both requesters valid.
//    - Required: mem_req_valid = 0, both ready = 0, err_orphan = 0.
//    - Then on the first cycle after rst, IF granted.
//  - Contention:
//    - Stimulus: both valid continuously, mem_req_ready = 1, responses 1 cycle later.
//    - Required: grants alternate IF, LS, IF, LS.
//    - Required: each response is routed to the matching owner.
//  - Stall lock:
//    - Stimulus: IF granted at 0x100, mem_req_ready = 0 for 3 cycles, then LS raises valid.
//    - Required: addr stays 0x100; LS is granted only after IF transfers.
//  - Full:
//    - Stimulus: OUTSTANDING = 2, 2 IF fetches accepted, no response.
//    - Required: mem_req_valid = 0.
//    - Stimulus: response 0xDEADBEEF arrives.
//    - Required: if_resp_valid = 1 with that data; the next grant happens the following cycle.
//  - Store:
//    - Stimulus: LS store at 0x40, wdata 0x12345678, wstrb 4'b0011.
//    - Required: forwarded unchanged.
//    - Required: ls_resp_valid pulses on the ack; if_resp_valid stays 0.
//  - Orphan:
//    - Stimulus: mem_resp_valid with count = 0.
//    - Required: err_orphan = 1 and stays set; no resp_valid.
//    - Stimulus: rst.
//    - Required: err_orphan = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS):
// round-robin grant that locks while memory stalls, plus an in-order owner FIFO for routing responses.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_we,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wstrb,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                err_orphan
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OUTSTANDING);

  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

  arb_state_t             state, state_nxt;
  logic                   rr;        // 0 = favour IF, 1 = favour LS
  logic                   hold_ls;
  logic                   granted, gnt_ls, xfer, push, pop, full, head;
  logic [OUTSTANDING-1:0] owner;     // 0 = IF, 1 = LS
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign full = (count == CNT_FULL);

  always_comb begin
    state_nxt = state;
    granted   = 1'b0;
    gnt_ls    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (!full && (if_req_valid || ls_req_valid)) begin
          granted = 1'b1;
          gnt_ls  = (if_req_valid && ls_req_valid) ? rr : ls_req_valid;
          if (!mem_req_ready) state_nxt = ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        granted = 1'b1;
        gnt_ls  = hold_ls;
        if (mem_req_ready) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (rst) granted = 1'b0;
  end

  assign mem_req_valid = granted;
  assign mem_req_addr  = gnt_ls ? ls_req_addr : if_req_addr;
  assign mem_req_we    = gnt_ls & ls_req_we;
  assign mem_req_wdata = gnt_ls ? ls_req_wdata : '0;
  assign mem_req_wstrb = gnt_ls ? ls_req_wstrb : '0;

  assign xfer         = granted && mem_req_ready;
  assign if_req_ready = xfer && !gnt_ls;
  assign ls_req_ready = xfer && gnt_ls;

  assign push = xfer;
  assign pop  = mem_resp_valid && (count != '0) && !rst;
  assign head = owner[rd_ptr];

  assign if_resp_valid = pop && !head;
  assign ls_resp_valid = pop && head;
  assign if_resp_data  = mem_resp_data;
  assign ls_resp_data  = mem_resp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      rr         <= 1'b0;
      hold_ls    <= 1'b0;
      owner      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && granted && !mem_req_ready) hold_ls <= gnt_ls;
      if (xfer) rr <= ~gnt_ls;
      if (push) begin
        owner[wr_ptr] <= gnt_ls;
        wr_ptr        <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem_resp_valid && count == '0) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter: one table row per clock cycle plus
// hand-written reset, orphan and mid-operation reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [31:0] if_req_addr, if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we, ls_resp_valid;
  logic [31:0] ls_req_addr, ls_req_wdata, ls_resp_data;
  logic [3:0]  ls_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [3:0]  mem_req_wstrb;
  logic        err_orphan;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_wdata(ls_req_wdata), .ls_req_wstrb(ls_req_wstrb),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .err_orphan(err_orphan)
  );

  typedef struct {
    logic        iv; logic [31:0] ia;
    logic        lv; logic [31:0] la; logic we; logic [31:0] wd; logic [3:0] ws;
    logic        mr; logic rv; logic [31:0] rd;
    logic        e_mv; logic [31:0] e_ma; logic e_we; logic [31:0] e_wd; logic [3:0] e_ws;
    logic        e_ir; logic e_lr; logic e_irv; logic e_lrv; logic e_err;
  } vec_t;

  localparam int NV = 27;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic lv, input logic [31:0] la,
                       input logic we, input logic [31:0] wd, input logic [3:0] ws,
                       input logic mr, input logic rv, input logic [31:0] rd);
    if_req_valid = iv; if_req_addr = ia;
    ls_req_valid = lv; ls_req_addr = la; ls_req_we = we; ls_req_wdata = wd; ls_req_wstrb = ws;
    mem_req_ready = mr; mem_resp_valid = rv; mem_resp_data = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // cols: iv ia lv la we wd ws mr rv rd | mv ma we wd ws ir lr irv lrv err
    // Contention: IF, LS alternate; LS side carries a store so the IF grant must zero its payload.
    vec[0]  = '{1,32'h10,1,32'h20,1,32'hCAFEF00D,4'hF,1,0,0,          1,32'h10,0,0,0,          1,0,0,0,0};
    vec[1]  = '{1,32'h14,1,32'h20,1,32'hCAFEF00D,4'hF,1,1,32'hA0,     1,32'h20,1,32'hCAFEF00D,4'hF,0,1,1,0,0};
    vec[2]  = '{1,32'h14,1,32'h24,1,32'hCAFEF00D,4'hF,1,1,32'hA1,     1,32'h14,0,0,0,          1,0,0,1,0};
    vec[3]  = '{1,32'h18,1,32'h24,1,32'hCAFEF00D,4'hF,1,1,32'hA2,     1,32'h24,1,32'hCAFEF00D,4'hF,0,1,1,0,0};
    vec[4]  = '{0,0,0,0,0,0,0,1,1,32'hA3,                              0,0,0,0,0,               0,0,0,1,0};
    // Stall lock on IF @0x100; LS appears mid-stall and waits.
    vec[5]  = '{1,32'h100,0,0,0,0,0,0,0,0,                             1,32'h100,0,0,0,         0,0,0,0,0};
    vec[6]  = '{1,32'h100,1,32'h200,0,0,0,0,0,0,                       1,32'h100,0,0,0,         0,0,0,0,0};
    vec[7]  = '{1,32'h100,1,32'h200,0,0,0,0,0,0,                       1,32'h100,0,0,0,         0,0,0,0,0};
    vec[8]  = '{1,32'h100,1,32'h200,0,0,0,1,0,0,                       1,32'h100,0,0,0,         1,0,0,0,0};
    vec[9]  = '{0,0,1,32'h200,0,0,0,1,0,0,                             1,32'h200,0,0,0,         0,1,0,0,0};
    // Full (IF+LS outstanding), pop does not unblock same cycle.
    vec[10] = '{1,32'h300,0,0,0,0,0,1,0,0,                             0,0,0,0,0,               0,0,0,0,0};
    vec[11] = '{1,32'h300,0,0,0,0,0,1,1,32'hDEADBEEF,                  0,0,0,0,0,               0,0,1,0,0};
    vec[12] = '{1,32'h300,0,0,0,0,0,1,0,0,                             1,32'h300,0,0,0,         1,0,0,0,0};
    vec[13] = '{0,0,0,0,0,0,0,1,1,32'h11,                              0,0,0,0,0,               0,0,0,1,0};
    vec[14] = '{0,0,0,0,0,0,0,1,1,32'h22,                              0,0,0,0,0,               0,0,1,0,0};
    // Full with two IF fetches.
    vec[15] = '{1,32'h400,0,0,0,0,0,1,0,0,                             1,32'h400,0,0,0,         1,0,0,0,0};
    vec[16] = '{1,32'h404,0,0,0,0,0,1,0,0,                             1,32'h404,0,0,0,         1,0,0,0,0};
    vec[17] = '{1,32'h408,0,0,0,0,0,1,0,0,                             0,0,0,0,0,               0,0,0,0,0};
    vec[18] = '{1,32'h408,0,0,0,0,0,1,1,32'hDEADBEEF,                  0,0,0,0,0,               0,0,1,0,0};
    vec[19] = '{1,32'h408,0,0,0,0,0,1,0,0,                             1,32'h408,0,0,0,         1,0,0,0,0};
    vec[20] = '{0,0,0,0,0,0,0,1,1,32'h33,                              0,0,0,0,0,               0,0,1,0,0};
    vec[21] = '{0,0,0,0,0,0,0,1,1,32'h44,                              0,0,0,0,0,               0,0,1,0,0};
    // Store forwarded unchanged, ack routed to LS.
    vec[22] = '{0,0,1,32'h40,1,32'h12345678,4'b0011,1,0,0,             1,32'h40,1,32'h12345678,4'b0011,0,1,0,0,0};
    vec[23] = '{0,0,0,0,0,0,0,1,1,32'h0,                               0,0,0,0,0,               0,0,0,1,0};
    // Orphan response: no routing, sticky error from the next cycle on.
    vec[24] = '{0,0,0,0,0,0,0,1,1,32'h55,                              0,0,0,0,0,               0,0,0,0,0};
    vec[25] = '{0,0,0,0,0,0,0,1,0,0,                                   0,0,0,0,0,               0,0,0,0,1};
    vec[26] = '{0,0,0,0,0,0,0,1,0,0,                                   0,0,0,0,0,               0,0,0,0,1};

    // Reset with both requesters asking.
    rst = 1'b1;
    drive(1, 32'h10, 1, 32'h20, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      chk($sformatf("rst%0d mem_req_valid", c), 32'(mem_req_valid), 0);
      chk($sformatf("rst%0d if_req_ready", c),  32'(if_req_ready), 0);
      chk($sformatf("rst%0d ls_req_ready", c),  32'(ls_req_ready), 0);
      chk($sformatf("rst%0d err_orphan", c),    32'(err_orphan), 0);
    end
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].iv, vec[i].ia, vec[i].lv, vec[i].la, vec[i].we, vec[i].wd, vec[i].ws,
            vec[i].mr, vec[i].rv, vec[i].rd);
      @(negedge clk);
      chk($sformatf("v%0d mem_req_valid", i), 32'(mem_req_valid), 32'(vec[i].e_mv));
      chk($sformatf("v%0d if_req_ready", i),  32'(if_req_ready),  32'(vec[i].e_ir));
      chk($sformatf("v%0d ls_req_ready", i),  32'(ls_req_ready),  32'(vec[i].e_lr));
      chk($sformatf("v%0d if_resp_valid", i), 32'(if_resp_valid), 32'(vec[i].e_irv));
      chk($sformatf("v%0d ls_resp_valid", i), 32'(ls_resp_valid), 32'(vec[i].e_lrv));
      chk($sformatf("v%0d err_orphan", i),    32'(err_orphan),    32'(vec[i].e_err));
      if (vec[i].e_mv) begin
        chk($sformatf("v%0d mem_req_addr", i),  mem_req_addr,       vec[i].e_ma);
        chk($sformatf("v%0d mem_req_we", i),    32'(mem_req_we),    32'(vec[i].e_we));
        chk($sformatf("v%0d mem_req_wdata", i), mem_req_wdata,      vec[i].e_wd);
        chk($sformatf("v%0d mem_req_wstrb", i), 32'(mem_req_wstrb), 32'(vec[i].e_ws));
      end
      if (vec[i].e_irv) chk($sformatf("v%0d if_resp_data", i), if_resp_data, vec[i].rd);
      if (vec[i].e_lrv) chk($sformatf("v%0d ls_resp_data", i), ls_resp_data, vec[i].rd);
      next_cycle();
    end

    // Reset clears the sticky orphan flag.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("orphan cleared by rst", 32'(err_orphan), 0);

    // Reset mid-operation: the accepted fetch's response becomes an orphan.
    next_cycle();
    drive(1, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("midrst fetch accepted", 32'(if_req_ready), 1);
    next_cycle();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h66);
    @(negedge clk);
    chk("midrst if_resp_valid", 32'(if_resp_valid), 0);
    chk("midrst ls_resp_valid", 32'(ls_resp_valid), 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("midrst err_orphan", 32'(err_orphan), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
